// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / MEM) writeback arbiter in front of a register file write port.
// Define WB_RR_EN for round-robin on different-address conflicts; default is fixed MEM priority.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_ADDR,
    input  logic [DATA_W-1:0] ALU_DATA,
    output logic              ALU_READY,
    input  logic              MEM_VALID,
    input  logic [ADDR_W-1:0] MEM_ADDR,
    input  logic [DATA_W-1:0] MEM_DATA,
    output logic              MEM_READY,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD3,
    output logic [1:0]        GRANT,
    output logic [7:0]        X0_DROP_CNT
);

    logic              r_alu_full;
    logic [ADDR_W-1:0] r_alu_addr;
    logic [DATA_W-1:0] r_alu_data;
    logic              r_mem_full;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_mem_older;
    logic              r_we3;
    logic [ADDR_W-1:0] r_a3;
    logic [DATA_W-1:0] r_wd3;
    logic [1:0]        r_grant;
    logic [7:0]        r_drop_cnt;
`ifdef WB_RR_EN
    logic              r_rr_mem_next;
`endif

    logic       w_both_full;
    logic       w_conflict;
    logic       w_gnt_alu;
    logic       w_gnt_mem;
    logic       w_alu_acc;
    logic       w_mem_acc;
    logic       w_alu_fill;
    logic       w_mem_fill;
    logic       w_alu_drop;
    logic       w_mem_drop;
    logic [8:0] w_cnt_sum;

    assign w_both_full = r_alu_full && r_mem_full;
    assign w_conflict  = w_both_full && (r_alu_addr != r_mem_addr);

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (w_both_full) begin
            if (!w_conflict) begin
                // Same destination: the older entry must land first so the newer value wins.
                w_gnt_mem = r_mem_older;
                w_gnt_alu = !r_mem_older;
            end else begin
`ifdef WB_RR_EN
                w_gnt_mem = r_rr_mem_next;
                w_gnt_alu = !r_rr_mem_next;
`else
                w_gnt_mem = 1'b1;
`endif
            end
        end else begin
            w_gnt_alu = r_alu_full;
            w_gnt_mem = r_mem_full;
        end
    end

    assign ALU_READY  = !r_alu_full || w_gnt_alu;
    assign MEM_READY  = !r_mem_full || w_gnt_mem;
    assign w_alu_acc  = ALU_VALID && ALU_READY;
    assign w_mem_acc  = MEM_VALID && MEM_READY;
    assign w_alu_fill = w_alu_acc && (ALU_ADDR != '0);
    assign w_mem_fill = w_mem_acc && (MEM_ADDR != '0);
    assign w_alu_drop = w_alu_acc && (ALU_ADDR == '0);
    assign w_mem_drop = w_mem_acc && (MEM_ADDR == '0);
    assign w_cnt_sum  = {1'b0, r_drop_cnt} + 9'(w_alu_drop) + 9'(w_mem_drop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_alu_full  <= 1'b0;
            r_alu_addr  <= '0;
            r_alu_data  <= '0;
            r_mem_full  <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_mem_older <= 1'b0;
        end else begin
            if (w_alu_fill) begin
                r_alu_full <= 1'b1;
                r_alu_addr <= ALU_ADDR;
                r_alu_data <= ALU_DATA;
            end else if (w_gnt_alu) begin
                r_alu_full <= 1'b0;
            end
            if (w_mem_fill) begin
                r_mem_full <= 1'b1;
                r_mem_addr <= MEM_ADDR;
                r_mem_data <= MEM_DATA;
            end else if (w_gnt_mem) begin
                r_mem_full <= 1'b0;
            end
            // A fresh ALU entry is never older than MEM; simultaneous fills also count MEM as older.
            if (w_alu_fill) begin
                r_mem_older <= 1'b1;
            end else if (w_mem_fill) begin
                r_mem_older <= 1'b0;
            end
        end
    end

`ifdef WB_RR_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_rr_mem_next <= 1'b0;
        end else if (w_conflict) begin
            r_rr_mem_next <= w_gnt_alu;
        end
    end
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_we3      <= 1'b0;
            r_a3       <= '0;
            r_wd3      <= '0;
            r_grant    <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_we3   <= w_gnt_alu || w_gnt_mem;
            r_grant <= {w_gnt_mem, w_gnt_alu};
            if (w_gnt_mem) begin
                r_a3  <= r_mem_addr;
                r_wd3 <= r_mem_data;
            end else if (w_gnt_alu) begin
                r_a3  <= r_alu_addr;
                r_wd3 <= r_alu_data;
            end
            r_drop_cnt <= w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        end
    end

    assign WE3         = r_we3;
    assign A3          = r_a3;
    assign WD3         = r_wd3;
    assign GRANT       = r_grant;
    assign X0_DROP_CNT = r_drop_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as stimulus is driven
// and popped whenever WE3 is seen. Honours WB_RR_EN to pick the expected conflict order.
module tb_regfile_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          CLK;
    logic          RST;
    logic          ALU_VALID;
    logic [AW-1:0] ALU_ADDR;
    logic [DW-1:0] ALU_DATA;
    logic          ALU_READY;
    logic          MEM_VALID;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_DATA;
    logic          MEM_READY;
    logic          WE3;
    logic [AW-1:0] A3;
    logic [DW-1:0] WD3;
    logic [1:0]    GRANT;
    logic [7:0]    X0_DROP_CNT;

    int n_vec = 0;
    int n_err = 0;

    logic [2+AW+DW-1:0] sb[$];
    logic [DW-1:0]      shadow[32];

    regfile_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_ADDR(ALU_ADDR), .ALU_DATA(ALU_DATA), .ALU_READY(ALU_READY),
        .MEM_VALID(MEM_VALID), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_READY(MEM_READY),
        .WE3(WE3), .A3(A3), .WD3(WD3), .GRANT(GRANT), .X0_DROP_CNT(X0_DROP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_vec++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic push_wr(input logic [1:0] g, input logic [AW-1:0] a, input logic [DW-1:0] d);
        sb.push_back({g, a, d});
    endtask

    always @(negedge CLK) begin
        logic [2+AW+DW-1:0] want;
        if (WE3 === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("stray_we3", WE3, 0);
            end else begin
                want = sb.pop_front();
                check_eq("wb_write", {GRANT, A3, WD3}, want);
                shadow[A3] = WD3;
            end
        end
    end

    // ALU A=3 and MEM A=4 accepted on the same edge, then drained.
    task automatic conflict_round(input logic [DW-1:0] da, input logic [DW-1:0] dm, input bit mem_first);
        check_eq("cf_alu_rdy", ALU_READY, 1);
        check_eq("cf_mem_rdy", MEM_READY, 1);
        ALU_VALID = 1'b1; ALU_ADDR = 5'd3; ALU_DATA = da;
        MEM_VALID = 1'b1; MEM_ADDR = 5'd4; MEM_DATA = dm;
        if (mem_first) begin
            push_wr(2'b10, 5'd4, dm);
            push_wr(2'b01, 5'd3, da);
        end else begin
            push_wr(2'b01, 5'd3, da);
            push_wr(2'b10, 5'd4, dm);
        end
        tick;
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        tick;
        check_eq("cf_grant_first", GRANT, mem_first ? 2'b10 : 2'b01);
        tick;
        check_eq("cf_grant_second", GRANT, mem_first ? 2'b01 : 2'b10);
        tick;
    endtask

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        bit mf;
        RST = 1'b0;
        ALU_VALID = 1'b0; ALU_ADDR = '0; ALU_DATA = '0;
        MEM_VALID = 1'b0; MEM_ADDR = '0; MEM_DATA = '0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        repeat (3) tick;
        check_eq("rst_we3", WE3, 0);
        check_eq("rst_grant", GRANT, 0);
        check_eq("rst_a3", A3, 0);
        check_eq("rst_wd3", WD3, 0);
        check_eq("rst_cnt", X0_DROP_CNT, 0);
        RST = 1'b1;
        check_eq("post_rst_alu_rdy", ALU_READY, 1);
        check_eq("post_rst_mem_rdy", MEM_READY, 1);

        // single ALU request and its two-edge latency
        ALU_VALID = 1'b1; ALU_ADDR = 5'd5; ALU_DATA = 32'h11;
        check_eq("single_rdy", ALU_READY, 1);
        push_wr(2'b01, 5'd5, 32'h11);
        tick;
        ALU_VALID = 1'b0;
        check_eq("single_lat_we3", WE3, 0);
        tick;
        check_eq("single_we3", WE3, 1);
        check_eq("single_a3", A3, 5);
        check_eq("single_wd3", WD3, 32'h11);
        check_eq("single_grant", GRANT, 2'b01);
        tick;
        check_eq("idle_we3", WE3, 0);
        check_eq("idle_grant", GRANT, 0);
        check_eq("idle_hold_a3", A3, 5);
        check_eq("idle_hold_wd3", WD3, 32'h11);

        // different-address conflicts; the warm-up round moves the RR pointer to MEM
`ifdef WB_RR_EN
        conflict_round(32'hA0, 32'hB0, 1'b0);
`else
        conflict_round(32'hA0, 32'hB0, 1'b1);
`endif
        for (int r = 0; r < 4; r++) begin
`ifdef WB_RR_EN
            mf = (r % 2 == 0);
`else
            mf = 1'b1;
`endif
            conflict_round(32'hA1 + r, 32'hB1 + r, mf);
        end

        // same-address ordering: ALU A=7 stalls behind MEM A=9, MEM refills A=7 one edge later
        ALU_VALID = 1'b1; ALU_ADDR = 5'd7; ALU_DATA = 32'd1;
        MEM_VALID = 1'b1; MEM_ADDR = 5'd9; MEM_DATA = 32'd9;
        push_wr(2'b10, 5'd9, 32'd9);
        tick;
        ALU_ADDR = 5'd11; ALU_DATA = 32'hBAD;
        MEM_ADDR = 5'd7;  MEM_DATA = 32'd2;
        check_eq("stall_alu_rdy", ALU_READY, 0);
        check_eq("refill_mem_rdy", MEM_READY, 1);
        push_wr(2'b01, 5'd7, 32'd1);
        push_wr(2'b10, 5'd7, 32'd2);
        tick;
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        check_eq("same_g0", GRANT, 2'b10);
        tick;
        check_eq("same_g1", GRANT, 2'b01);
        tick;
        check_eq("same_g2", GRANT, 2'b10);
        tick;
        check_eq("same_final_r7", shadow[7], 32'd2);

        // back-to-back ALU stream
        for (int i = 0; i < 8; i++) begin
            ALU_VALID = 1'b1; ALU_ADDR = AW'(i + 1); ALU_DATA = 32'h100 * (i + 1);
            check_eq("b2b_rdy", ALU_READY, 1);
            push_wr(2'b01, AW'(i + 1), 32'h100 * (i + 1));
            tick;
            if (i > 0) check_eq("b2b_we3", WE3, 1);
        end
        ALU_VALID = 1'b0;
        tick;
        check_eq("b2b_we3_last", WE3, 1);
        tick;
        check_eq("b2b_we3_end", WE3, 0);

        // register-0 writes are dropped and counted, saturating at 255
        MEM_VALID = 1'b1; MEM_ADDR = '0; MEM_DATA = 32'hDEAD;
        repeat (3) tick;
        check_eq("x0_cnt3", X0_DROP_CNT, 3);
        check_eq("x0_we3", WE3, 0);
        repeat (251) tick;
        check_eq("x0_cnt254", X0_DROP_CNT, 254);
        tick;
        check_eq("x0_cnt255", X0_DROP_CNT, 255);
        repeat (45) tick;
        check_eq("x0_cnt_sat", X0_DROP_CNT, 255);
        check_eq("x0_mem_rdy", MEM_READY, 1);
        MEM_VALID = 1'b0;

        // reset mid-traffic: both entries just filled, then lost
        ALU_VALID = 1'b1; ALU_ADDR = 5'd12; ALU_DATA = 32'hC12;
        MEM_VALID = 1'b1; MEM_ADDR = 5'd13; MEM_DATA = 32'hC13;
        tick;
        ALU_VALID = 1'b0; MEM_VALID = 1'b0;
        #1 RST = 1'b0;
        #1;
        check_eq("mid_rst_we3", WE3, 0);
        check_eq("mid_rst_grant", GRANT, 0);
        check_eq("mid_rst_a3", A3, 0);
        check_eq("mid_rst_wd3", WD3, 0);
        check_eq("mid_rst_cnt", X0_DROP_CNT, 0);
        tick;
        RST = 1'b1;
        check_eq("mid_rel_alu_rdy", ALU_READY, 1);
        check_eq("mid_rel_mem_rdy", MEM_READY, 1);
        repeat (4) tick;
        check_eq("mid_rel_we3", WE3, 0);

        check_eq("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, register address width; DATA_W, 32, write data width.
REQ-002 CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 ALU_VALID  input  1  ALU writeback request valid.
REQ-005 ALU_ADDR  input  ADDR_W  ALU destination register.
REQ-006 ALU_DATA  input  DATA_W  ALU writeback data.
REQ-007 ALU_READY  output  1  ALU request accepted when ALU_VALID and ALU_READY are both high at a rising edge.
REQ-008 MEM_VALID, MEM_ADDR, MEM_DATA, MEM_READY SHALL match the ALU ports in direction, width and meaning, for the cache/load-return requester.
REQ-009 WE3  output  1  registered write enable to the register file write port.
REQ-010 A3  output  ADDR_W  registered write address.
REQ-011 WD3  output  DATA_W  registered write data.
REQ-012 GRANT  output  2  registered one-hot grant for the current WE3 cycle: bit0 ALU, bit1 MEM, 00 when idle.
REQ-013 X0_DROP_CNT  output  8  count of discarded writes to register 0.

Function
REQ-014 Each requester SHALL own a one-entry holding register (addr, data, full flag).
REQ-015 READY SHALL be combinational: !full, or full and granted in the current cycle (same-cycle refill).
REQ-016 An accepted request with addr != 0 SHALL set full at the accepting edge.
REQ-017 An accepted request with addr == 0 SHALL be discarded: full stays clear, X0_DROP_CNT increments, saturating at 255.
REQ-018 Each cycle the arbiter SHALL select one full holding register; WE3/A3/WD3/GRANT SHALL show the selection after the next edge, and the selected entry's full flag SHALL clear at that edge.
REQ-019 Latency SHALL be: accept at edge N, earliest WE3 high after edge N+1, register file written at edge N+2.
REQ-020 With no full entry, the next edge SHALL set WE3=0 and GRANT=00; A3/WD3 SHALL hold their last values.
REQ-021 An age bit SHALL record which entry was filled first; if both are full with equal addresses, the older SHALL always be granted first.
REQ-022 Entries filled at the same edge SHALL be treated as MEM older.
REQ-023 Both full with different addresses SHALL follow the policy in Configuration.
REQ-024 Only one requester SHALL be granted per cycle; the other SHALL keep its entry and its READY SHALL stay low.
REQ-025 VALID without READY SHALL not change any state.
REQ-026 Sustained throughput SHALL be one write per cycle while any entry is full.

Reset
REQ-027 RST low SHALL immediately clear both full flags, the age bit and the round-robin pointer (ALU next).
REQ-028 RST low SHALL immediately set WE3=0, A3=0, WD3=0, GRANT=00 and X0_DROP_CNT=0.
REQ-029 Requests held when reset asserts SHALL be lost with no partial write.
REQ-030 READY SHALL be high in the first cycle after RST deasserts.

Configuration
REQ-031 The policy macro SHALL be WB_RR_EN.
REQ-032 With WB_RR_EN defined, different-address conflicts SHALL use round-robin: the pointer toggles to the other requester after each conflict grant.
REQ-033 With WB_RR_EN undefined, MEM SHALL have fixed priority over ALU and the pointer logic SHALL be absent.
REQ-034 REQ-021 and REQ-022 SHALL apply in both builds.

Verification
REQ-035 Reset check: RST low mid-traffic -> WE3=0, GRANT=00, counter 0 and both READY high the cycle after release, with no stray write.
REQ-036 Single request: ALU (A=5, D=0x11) -> two edges later WE3=1, A3=5, WD3=0x11, GRANT=01.
REQ-037 Register 0 writes: MEM writes A=0 three times -> WE3 never high, X0_DROP_CNT=3; 300 writes -> count saturates at 255.
REQ-038 Different-address conflict: ALU A=3 and MEM A=4 accepted at the same edge, repeated 4 times -> RR build alternates grants MEM,ALU,MEM,ALU...; fixed build grants MEM before ALU each time.
REQ-039 Same-address conflict: ALU A=7 D=1 accepted, MEM A=7 D=2 accepted one edge later while ALU is stalled -> ALU write first, MEM write next, final value 2.
REQ-040 Back-to-back: ALU VALID held for 8 cycles with MEM idle -> ALU_READY stays high, 8 consecutive WE3 cycles.
